// File: rtl/nexys_starship_pkg.sv
// Shared constants for the starship damage scheduler and its random source.
// State codes are fixed values so that debug LEDs/SSD decoding stays stable.
package nexys_starship_pkg;

    localparam logic [2:0] ST_IDLE   = 3'b001;
    localparam logic [2:0] ST_COUNT  = 3'b010;
    localparam logic [2:0] ST_SELECT = 3'b100;
    localparam logic [2:0] ST_FIRE   = 3'b000;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One right-shift Galois step; the taps are applied when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Galois LFSR, shared by the randomised game blocks.
// It advances on every clock outside reset, independent of game state.
module nexys_starship_lfsr16 (
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] lfsr
);
    import nexys_starship_pkg::*;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

endmodule

// File: rtl/nexys_starship_damage_sched.sv
// Central damage scheduler: after a random tick interval it breaks one working subsystem,
// and it pulses overload_gameover when too many subsystems stay broken for too long.
module nexys_starship_damage_sched #(
    parameter int NUM_SUB     = 4,
    parameter int TICK_DIV    = 25_000_000,
    parameter int BASE_TICKS  = 8,
    parameter int MAX_BROKEN  = 3,
    parameter int GRACE_TICKS = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               play_flag,
    input  logic               gameover_ctrl,
    input  logic [1:0]         difficulty,
    input  logic [NUM_SUB-1:0] broken_status,
    output logic [NUM_SUB-1:0] break_req,
    output logic [3:0]         break_hex,
    output logic               overload_gameover,
    output logic [2:0]         sched_state
);
    import nexys_starship_pkg::*;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(NUM_SUB);
    localparam int CW = $clog2(NUM_SUB + 1);
    localparam int OW = $clog2(GRACE_TICKS + 1);

    logic [2:0]    state;
    logic [PW-1:0] presc;
    logic [7:0]    icnt;
    logic [OW-1:0] ocnt;
    logic [SW-1:0] cand;
    logic [SW-1:0] scan;
    logic [15:0]   lfsr;
    logic [CW-1:0] broken_cnt;
    logic          tick;
    logic          overloaded;
    logic          stop;
    logic [7:0]    load_val;
    logic [SW-1:0] first_cand;
    logic [SW-1:0] next_cand;
    logic          unused_lfsr_bits;

    nexys_starship_lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .lfsr  (lfsr)
    );

    always_comb begin
        broken_cnt = '0;
        for (int i = 0; i < NUM_SUB; i++) begin
            broken_cnt = broken_cnt + CW'(broken_status[i]);
        end
    end

    assign overloaded  = int'(broken_cnt) >= MAX_BROKEN;
    assign stop        = gameover_ctrl || !play_flag;
    assign tick        = (state != ST_IDLE) && (presc == PW'(TICK_DIV - 1));
    assign load_val    = 8'(BASE_TICKS - 2 * int'(difficulty) + int'(lfsr[1:0]));
    assign first_cand  = SW'(int'(lfsr[2:0]) % NUM_SUB);
    assign next_cand   = (cand == SW'(NUM_SUB - 1)) ? '0 : cand + 1'b1;
    assign sched_state = state;
    assign unused_lfsr_bits = ^{lfsr[15:8], lfsr[3]};

    // Leaving play (or a game over) wins over any tick and aborts a pending FIRE;
    // break_hex deliberately keeps the last combo so the display stays meaningful.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state             <= ST_IDLE;
            presc             <= '0;
            icnt              <= '0;
            ocnt              <= '0;
            cand              <= '0;
            scan              <= '0;
            break_req         <= '0;
            break_hex         <= '0;
            overload_gameover <= 1'b0;
        end else begin
            break_req         <= '0;
            overload_gameover <= 1'b0;
            if (state == ST_IDLE) begin
                if (!stop) begin
                    icnt  <= load_val;
                    state <= ST_COUNT;
                end
            end else if (stop) begin
                state <= ST_IDLE;
                presc <= '0;
                icnt  <= '0;
                ocnt  <= '0;
                cand  <= '0;
                scan  <= '0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;

                if (!overloaded) begin
                    ocnt <= '0;
                end else if (tick) begin
                    if (ocnt == OW'(GRACE_TICKS - 1)) begin
                        overload_gameover <= 1'b1;
                        ocnt              <= '0;
                    end else begin
                        ocnt <= ocnt + 1'b1;
                    end
                end

                case (state)
                    ST_COUNT: begin
                        if (tick) begin
                            if (icnt != 8'd0) begin
                                icnt <= icnt - 8'd1;
                            end else if (overloaded) begin
                                icnt <= load_val;
                            end else begin
                                cand  <= first_cand;
                                scan  <= '0;
                                state <= ST_SELECT;
                            end
                        end
                    end
                    ST_SELECT: begin
                        if (!broken_status[cand]) begin
                            break_req <= NUM_SUB'(1) << cand;
                            break_hex <= lfsr[7:4];
                            state     <= ST_FIRE;
                        end else if (scan == SW'(NUM_SUB - 1)) begin
                            icnt  <= load_val;
                            state <= ST_COUNT;
                        end else begin
                            cand <= next_cand;
                            scan <= scan + 1'b1;
                        end
                    end
                    ST_FIRE: begin
                        icnt  <= load_val;
                        state <= ST_COUNT;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
